// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: state encoding, default widths
// and the MEM/WB bubble value.
package mem_stage_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int RD_W_DEF     = 4;
   localparam int MAX_WAIT_DEF = 15;
   localparam int CNT_W        = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/mem_wb_regs.sv
// MEM/WB boundary register bank. Loads every edge; a bubble select loads a
// no-op so writeback never sees a stalled or aborted instruction.
module mem_wb_regs
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = RD_W_DEF
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              bubble,
   input  logic              regwrite_d,
   input  logic              pcwrite_d,
   input  logic [DATA_W-1:0] data_d,
   input  logic [RD_W-1:0]   rd_d,
   output logic              wb_regwrite,
   output logic              wb_pcwrite,
   output logic [DATA_W-1:0] wb_data,
   output logic [RD_W-1:0]   wb_rd
);

   always_ff @(posedge clock) begin
      if (rst || bubble) begin
         wb_regwrite <= BUBBLE_CTRL;
         wb_pcwrite  <= BUBBLE_CTRL;
         wb_data     <= '0;
         wb_rd       <= '0;
      end else begin
         wb_regwrite <= regwrite_d;
         wb_pcwrite  <= pcwrite_d;
         wb_data     <= data_d;
         wb_rd       <= rd_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: req/ack handshake with a variable-latency data memory,
// upstream stall generation, access timeout and MEM/WB registration.
//
// state | meaning
// IDLE  | no access outstanding; an access request stalls one cycle and issues req
// WAIT  | req outstanding; waiting for ack or for the wait counter to expire
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RD_W     = RD_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [DATA_W-1:0] mem_aluout,
   input  logic [DATA_W-1:0] mem_b,
   input  logic              mem2reg_in,
   input  logic              memwrite_in,
   input  logic              regwrite_in,
   input  logic              pcwrite_in,
   input  logic [RD_W-1:0]   rd_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall,
   output logic              wb_regwrite,
   output logic              wb_pcwrite,
   output logic [DATA_W-1:0] wb_data,
   output logic [RD_W-1:0]   wb_rd,
   output logic              bus_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   wait_cnt;
   logic               access;
   logic               done_now;
   logic               abort_now;
   logic               bubble;
   logic [DATA_W-1:0]  wb_data_d;

   assign access    = mem2reg_in | memwrite_in;
   assign done_now  = (state == ST_WAIT) & dmem_ack;
   assign abort_now = (state == ST_WAIT) & ~dmem_ack & (wait_cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (access) begin
               stall     = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done_now || abort_now) state_nxt = ST_IDLE;
            else                       stall     = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Address, data and direction are only written when leaving IDLE, so they
   // stay frozen for the whole time req is high.
   always_ff @(posedge clock) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wait_cnt   <= '0;
         bus_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (access) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= memwrite_in;
                  dmem_addr  <= mem_aluout;
                  dmem_wdata <= mem_b;
                  wait_cnt   <= '0;
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
               end else if (abort_now) begin
                  dmem_req <= 1'b0;
                  bus_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: dmem_req <= 1'b0;
         endcase
      end
   end

   // A load that is also a store counts as a store, so it never takes rdata.
   assign bubble    = stall | abort_now;
   assign wb_data_d = (done_now && mem2reg_in && !memwrite_in) ? dmem_rdata : mem_aluout;

   mem_wb_regs #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W)
   ) u_mem_wb_regs (
      .clock       (clock),
      .rst         (rst),
      .bubble      (bubble),
      .regwrite_d  (regwrite_in),
      .pcwrite_d   (pcwrite_in),
      .data_d      (wb_data_d),
      .rd_d        (rd_in),
      .wb_regwrite (wb_regwrite),
      .wb_pcwrite  (wb_pcwrite),
      .wb_data     (wb_data),
      .wb_rd       (wb_rd)
   );

endmodule
